// File: rtl/uart_rx_fifo.sv
// Receive buffer between the buart receiver and the CPU bus: drains bytes from buart into a
// first-word-fall-through FIFO and raises a level-triggered irq at a programmable occupancy.
module uart_rx_fifo #(
    parameter int unsigned DepthLog2 = 4,
    parameter int unsigned Width     = 8
) (
    input  logic                 clk_i,
    input  logic                 resetq_i,
    input  logic                 uart_valid_i,
    input  logic [Width-1:0]     uart_data_i,
    output logic                 uart_rd_o,
    input  logic                 pop_i,
    output logic [Width-1:0]     head_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [DepthLog2:0]   level_o,
    input  logic                 thresh_we_i,
    input  logic [DepthLog2:0]   thresh_in_i,
    output logic                 irq_o
);

    localparam int unsigned Depth = 2 ** DepthLog2;
    localparam logic [DepthLog2:0] DepthLvl = Depth[DepthLog2:0];

    typedef enum logic {StIdle, StAck} state_e;

    state_e                 state_q, state_d;
    logic [Width-1:0]       mem_q [Depth];
    logic [DepthLog2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DepthLog2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DepthLog2:0]     level_q, level_d;
    logic [DepthLog2:0]     thresh_q, thresh_d;
    logic                   uart_rd_q, uart_rd_d;
    logic                   push;
    logic                   pop_ok;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == DepthLvl);
    assign level_o   = level_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign uart_rd_o = uart_rd_q;
    assign irq_o     = (thresh_q != '0) && (level_q >= thresh_q);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Full blocks capture even if a pop lands on the same edge; the byte waits in buart.
                if (uart_valid_i && !full_o) begin
                    push    = 1'b1;
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        uart_rd_d = push;
        pop_ok    = pop_i && !empty_o;
        wr_ptr_d  = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({push, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        thresh_d = thresh_q;
        if (thresh_we_i) begin
            thresh_d = (thresh_in_i > DepthLvl) ? DepthLvl : thresh_in_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetq_i) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            thresh_q  <= '0;
            uart_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            thresh_q  <= thresh_d;
            uart_rd_q <= uart_rd_d;
        end
    end

    // Storage is never cleared; reset only suppresses a write on its edge.
    always_ff @(posedge clk_i) begin
        if (resetq_i && push) begin
            mem_q[wr_ptr_q] <= uart_data_i;
        end
    end

endmodule
